// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - payload structs and widths for pipe_stage_reg boundaries
package riscv_pipe_pkg;

  localparam int XLEN          = 32;
  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } if_id_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    alu_op_e         alu_op;
    logic            mem_rd;
    logic            mem_wr;
    logic            reg_wr;
  } id_ex_t;

  typedef struct packed {
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] store_val;
    logic [4:0]      rd;
    logic            mem_rd;
    logic            mem_wr;
    logic            reg_wr;
  } ex_mem_t;

  typedef struct packed {
    logic [XLEN-1:0] wb_val;
    logic [4:0]      rd;
    logic            reg_wr;
  } mem_wb_t;

  localparam int IF_ID_W  = $bits(if_id_t);
  localparam int ID_EX_W  = $bits(id_ex_t);
  localparam int EX_MEM_W = $bits(ex_mem_t);
  localparam int MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !(&cnt)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic pipeline stage register with flush and stall counter
// Optional registered-ready skid buffer: define PIPE_STAGE_SKID_EN.
module pipe_stage_reg
  import riscv_pipe_pkg::*;
#(
  parameter int                DATA_W         = 32,
  parameter int                CNT_W          = CNT_W_DEFAULT,
  parameter bit                CLEAR_ON_FLUSH = 1'b1,
  parameter logic [DATA_W-1:0] RESET_VAL      = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  input  logic              stall_cnt_clr_i
);

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              main_free;
  logic              in_fire;

  // Ready depends only on the skid flop, breaking the combinational ready chain.
  assign in_ready_o = !skid_valid;
  assign main_free  = !out_valid_o || out_ready_i;
  assign in_fire    = in_valid_i && !skid_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_o <= 1'b0;
      out_data_o  <= RESET_VAL;
      skid_valid  <= 1'b0;
      skid_data   <= RESET_VAL;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
      skid_valid  <= 1'b0;
      if (CLEAR_ON_FLUSH) begin
        out_data_o <= RESET_VAL;
        skid_data  <= RESET_VAL;
      end
    end else if (main_free) begin
      if (skid_valid) begin
        out_valid_o <= 1'b1;
        out_data_o  <= skid_data;
        skid_valid  <= 1'b0;
      end else begin
        out_valid_o <= in_fire;
        if (in_fire) begin
          out_data_o <= in_data_i;
        end
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data_i;
    end
  end
`else
  assign in_ready_o = !out_valid_o || out_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_o <= 1'b0;
      out_data_o  <= RESET_VAL;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
      if (CLEAR_ON_FLUSH) begin
        out_data_o <= RESET_VAL;
      end
    end else if (in_ready_o) begin
      out_valid_o <= in_valid_i;
      if (in_valid_i) begin
        out_data_o <= in_data_i;
      end
    end
  end
`endif

  logic stall_inc;
  assign stall_inc = out_valid_o && !out_ready_i && !flush_i;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .clr (stall_cnt_clr_i),
    .cnt (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, iv, ordy, clr;
  logic [31:0] idata;
  logic        rdy, ov, rdy4, ov4;
  logic [31:0] od, od4;
  logic [15:0] cnt;
  logic [3:0]  cnt4;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(iv), .in_ready_o(rdy),
    .in_data_i(idata), .out_valid_o(ov), .out_ready_i(ordy), .out_data_o(od),
    .stall_cnt_o(cnt), .stall_cnt_clr_i(clr)
  );

  pipe_stage_reg #(.DATA_W(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(iv), .in_ready_o(rdy4),
    .in_data_i(idata), .out_valid_o(ov4), .out_ready_i(ordy), .out_data_o(od4),
    .stall_cnt_o(cnt4), .stall_cnt_clr_i(clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, flush, iv;
    logic [31:0] d;
    logic        ordy, clr;
    logic        e_rdy, e_v;
    logic [31:0] e_d;
    int          e_c;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic f, input logic v, input logic [31:0] d,
                     input logic o, input logic c, input logic er, input logic ev,
                     input logic [31:0] ed, input int ec);
    vec_t x;
    x.rst = r; x.flush = f; x.iv = v; x.d = d; x.ordy = o; x.clr = c;
    x.e_rdy = er; x.e_v = ev; x.e_d = ed; x.e_c = ec;
    tbl.push_back(x);
  endtask

  task automatic drive(input logic r, input logic f, input logic v, input logic [31:0] d,
                       input logic o, input logic c);
    rst = r; flush = f; iv = v; idata = d; ordy = o; clr = c;
  endtask

  logic [31:0] q[$];
  int          mc, mc4;
  logic        exp_rdy, stall;

  initial begin
    drive(1, 0, 0, 0, 1, 0);

    // reset with a pending input
    add(1, 0, 1, 32'hDEADBEEF, 1, 0, 1, 0, 0, 0);
    add(1, 0, 1, 32'hDEADBEEF, 1, 0, 1, 0, 0, 0);
    // streaming
    for (int k = 1; k <= 4; k++) add(0, 0, 1, k, 1, 0, 1, 1, k, 0);
    // backpressure on 5 while 6 is offered
    add(0, 0, 1, 5, 1, 0, 1, 1, 5, 0);
    add(0, 0, 1, 6, 0, 0, SKID, 1, 5, 1);
    add(0, 0, 1, 6, 0, 0, 0, 1, 5, 2);
    add(0, 0, 1, 6, 0, 0, 0, 1, 5, 3);
    add(0, 0, 1, 6, 1, 0, !SKID, 1, 6, 3);
    add(0, 0, 0, 0, 1, 0, 1, 0, 6, 3);
    // flush a stalled 9 while 10 is offered
    add(0, 0, 1, 9, 0, 0, 1, 1, 9, 3);
    add(0, 0, 0, 0, 0, 0, SKID, 1, 9, 4);
    add(0, 1, 1, 10, 0, 0, SKID, 0, 0, 4);
    add(0, 0, 0, 0, 1, 0, 1, 0, 0, 4);
    add(0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    // reset mid-stall with count 7
    add(0, 0, 1, 7, 0, 0, 1, 1, 7, 0);
    for (int k = 1; k <= 7; k++) add(0, 0, 0, 0, 0, 0, SKID, 1, 7, k);
    add(1, 0, 1, 32'hAB, 0, 0, SKID, 0, 0, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].flush, tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].clr);
      #1;
      if (i > 0) chk($sformatf("tbl%0d_in_ready", i), rdy, tbl[i].e_rdy);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_valid", i), ov, tbl[i].e_v);
      chk($sformatf("tbl%0d_data", i), od, tbl[i].e_d);
      chk($sformatf("tbl%0d_cnt", i), cnt, tbl[i].e_c);
      chk($sformatf("tbl%0d_cnt4", i), cnt4, (tbl[i].e_c > 15) ? 15 : tbl[i].e_c);
    end

    // saturation: load one entry, then stall 20 cycles
    @(negedge clk);
    drive(0, 0, 1, 32'h55, 0, 0);
    @(negedge clk);
    iv = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("sat_valid", ov, 1);
    chk("sat_data", od, 32'h55);
    chk("sat_cnt16", cnt, 20);
    chk("sat_cnt4", cnt4, 15);
    @(negedge clk);
    clr = 1;
    @(posedge clk);
    #1;
    chk("clr_cnt16", cnt, 0);
    chk("clr_cnt4", cnt4, 0);
    @(negedge clk);
    clr = 0;
    @(posedge clk);
    #1;
    chk("post_clr_cnt4", cnt4, 1);
    @(negedge clk);
    drive(1, 0, 0, 0, 1, 0);
    @(posedge clk);
    #1;
    chk("rst2_valid", ov, 0);
    chk("rst2_cnt", cnt, 0);

    // randomized run against a queue model
    q.delete();
    mc = 0;
    mc4 = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      drive(($urandom_range(63) == 0), ($urandom_range(15) == 0), ($urandom_range(3) != 0),
            $urandom, $urandom_range(1), ($urandom_range(31) == 0));
      #1;
      exp_rdy = SKID ? (q.size() < 2) : (q.size() == 0 || ordy);
      chk("rnd_in_ready", rdy, exp_rdy);
      chk("rnd_in_ready4", rdy4, exp_rdy);
      @(posedge clk);
      if (rst) begin
        q.delete();
        mc = 0;
        mc4 = 0;
      end else begin
        stall = (q.size() > 0) && !ordy && !flush;
        if (clr) begin
          mc = 0;
          mc4 = 0;
        end else if (stall) begin
          if (mc < 65535) mc++;
          if (mc4 < 15) mc4++;
        end
        if (flush) begin
          q.delete();
        end else begin
          if (q.size() > 0 && ordy) void'(q.pop_front());
          if (iv && exp_rdy) q.push_back(idata);
        end
      end
      #1;
      chk("rnd_valid", ov, q.size() > 0);
      chk("rnd_valid4", ov4, q.size() > 0);
      if (q.size() > 0) chk("rnd_data", od, q[0]);
      chk("rnd_cnt", cnt, mc);
      chk("rnd_cnt4", cnt4, mc4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
